// File: rtl/fix_tcp_pkg.sv
// Shared types for the FIX TCP link controller.
//   toe_cmd_e    : command codes sent to the TCP offload engine (11 is reserved, never sent)
//   link_state_e : link supervisor FSM states, also the debug encoding on state_o
//   addr_t       : 16-bit host address
//   max3()       : constant helper used to size the shared cycle timer
package fix_tcp_pkg;

  typedef enum logic [1:0] {
    CMD_OPEN   = 2'b00,
    CMD_LISTEN = 2'b01,
    CMD_CLOSE  = 2'b10
  } toe_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ_OPEN  = 3'd1,
    ST_WAIT_EST  = 3'd2,
    ST_UP        = 3'd3,
    ST_REQ_CLOSE = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_FAIL      = 3'd6
  } link_state_e;

  typedef logic [15:0] addr_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fix_tcp_link_ctrl_if.sv
// Command/status bundle between the link controller and the TCP offload engine.
//   toe_req_o   : command request (controller -> TOE)
//   toe_cmd_o   : command code, see fix_tcp_pkg::toe_cmd_e
//   toe_addr_o  : host address travelling with the command
//   toe_ack_i   : TOE accepts the command
//   toe_est_i   : level, TCP session established
//   toe_abort_i : pulse, peer reset / TOE abort
//
// Handshake: toe_req_o acts as valid and toe_ack_i as ready. A command transfers on
// every rising clk edge where toe_req_o & toe_ack_i are both high. While toe_req_o is
// high and not yet acknowledged, toe_cmd_o and toe_addr_o do not change. Only one
// command is outstanding at a time; toe_req_o is low in the cycle after a transfer
// unless a different, new command is issued immediately.
interface fix_tcp_link_ctrl_if;
  import fix_tcp_pkg::*;

  logic       toe_req_o;
  logic [1:0] toe_cmd_o;
  addr_t      toe_addr_o;
  logic       toe_ack_i;
  logic       toe_est_i;
  logic       toe_abort_i;

  modport master (
    output toe_req_o, toe_cmd_o, toe_addr_o,
    input  toe_ack_i, toe_est_i, toe_abort_i
  );

  modport slave (
    input  toe_req_o, toe_cmd_o, toe_addr_o,
    output toe_ack_i, toe_est_i, toe_abort_i
  );

endinterface

// File: rtl/fix_cyc_timer.sv
// Saturating cycle counter with a terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : restart the count at zero (wins over en_i)
//   en_i     : count one cycle
//   term_i   : terminal value to compare against
//   hit_o    : count equals term_i
// The count stops at all-ones and never wraps, so a stale timer cannot alias back
// onto a small terminal value.
module fix_cyc_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/fix_tcp_link_ctrl.sv
// FIX TCP link controller: turns the connect-stage request (connect/address/listen)
// into open/listen/close commands for the TCP offload engine, supervises session
// establishment with a timeout, retries with back-off, and reports link state.
//   clk, rst      : clock, synchronous active-high reset (TOE is reset alongside,
//                   so no close is issued on reset)
//   connect_i     : level, 1 = link wanted
//   address_i     : host address, captured when leaving IDLE
//   listen_i      : 1 = passive listen, 0 = active open; captured with the address
//   toe           : command/status bundle to the TOE (master side)
//   rx_activity_i : pulse per received byte, feeds the optional rx watchdog
//   link_up_o     : session established and usable
//   link_fail_o   : one-cycle pulse on retries exhausted, link drop or abort in UP
//   retry_cnt_o   : failed attempts in this connect episode, saturating at 15
//   state_o       : FSM state for debug (fix_tcp_pkg::link_state_e encoding)
// Build option: define FIX_LINK_WDOG_EN to enable the rx-inactivity watchdog in UP.
module fix_tcp_link_ctrl
  import fix_tcp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int BACKOFF_CYC = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int WDOG_CYC    = 200000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       connect_i,
  input  addr_t                      address_i,
  input  logic                       listen_i,
  fix_tcp_link_ctrl_if.master        toe,
  input  logic                       rx_activity_i,
  output logic                       link_up_o,
  output logic                       link_fail_o,
  output logic [3:0]                 retry_cnt_o,
  output logic [2:0]                 state_o
);

  localparam int TW = $clog2(max3(TIMEOUT_CYC, BACKOFF_CYC, WDOG_CYC) + 1);
  localparam logic [TW-1:0] TIMEOUT_TERM = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] BACKOFF_TERM = TW'(BACKOFF_CYC - 1);

  link_state_e   state_q, state_d;
  addr_t         addr_q;
  toe_cmd_e      mode_q;
  logic [3:0]    retry_q;
  logic          failed_q;    // the close in progress ends a failed attempt
  logic          cancel_q;    // connect_i dropped while the open was pending
  logic          fail_q;

  logic          latch_open;
  logic          retry_inc;
  logic          fail_att;
  logic          fail_pulse;
  logic          wdog_kick;
  logic          wdog_hit;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_hit;
  logic [TW-1:0] tmr_term;

  // One timer serves timeout, back-off and watchdog: they live in disjoint states
  // and the timer restarts on every state change.
  fix_cyc_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .hit_o  (tmr_hit)
  );

`ifdef FIX_LINK_WDOG_EN
  localparam logic [TW-1:0] WDOG_TERM = TW'(WDOG_CYC - 1);
  assign wdog_kick = (state_q == ST_UP) && rx_activity_i;
  assign wdog_hit  = (state_q == ST_UP) && tmr_hit;
`else
  localparam logic [TW-1:0] WDOG_TERM = TIMEOUT_TERM;
  logic unused_rx;
  assign unused_rx = rx_activity_i;
  assign wdog_kick = 1'b0;
  assign wdog_hit  = 1'b0;
`endif

  always_comb begin
    tmr_term = TIMEOUT_TERM;
    unique case (state_q)
      ST_BACKOFF: tmr_term = BACKOFF_TERM;
      ST_UP:      tmr_term = WDOG_TERM;
      default:    tmr_term = TIMEOUT_TERM;
    endcase
  end

  assign tmr_en  = (state_q == ST_WAIT_EST) || (state_q == ST_BACKOFF) || (state_q == ST_UP);
  assign tmr_clr = (state_d != state_q) || wdog_kick;

  // Next-state and event strobes.
  always_comb begin
    state_d    = state_q;
    latch_open = 1'b0;
    retry_inc  = 1'b0;
    fail_att   = 1'b0;
    fail_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (connect_i) begin
          state_d    = ST_REQ_OPEN;
          latch_open = 1'b1;
        end
      end
      ST_REQ_OPEN: begin
        // A cancel cannot withdraw a pending request; it turns into a close.
        if (toe.toe_ack_i) begin
          state_d = (connect_i && !cancel_q) ? ST_WAIT_EST : ST_REQ_CLOSE;
        end
      end
      ST_WAIT_EST: begin
        if (toe.toe_abort_i) begin
          state_d   = ST_REQ_CLOSE;
          retry_inc = 1'b1;
          fail_att  = 1'b1;
        end else if (!connect_i) begin
          state_d = ST_REQ_CLOSE;
        end else if (toe.toe_est_i) begin
          state_d = ST_UP;
        end else if ((mode_q == CMD_OPEN) && tmr_hit) begin
          state_d   = ST_REQ_CLOSE;
          retry_inc = 1'b1;
          fail_att  = 1'b1;
        end
      end
      ST_UP: begin
        // Loss of the session outranks an orderly teardown requested the same cycle.
        if (toe.toe_abort_i || !toe.toe_est_i || wdog_hit) begin
          state_d    = ST_REQ_CLOSE;
          fail_pulse = 1'b1;
        end else if (!connect_i) begin
          state_d = ST_REQ_CLOSE;
        end
      end
      ST_REQ_CLOSE: begin
        if (toe.toe_ack_i) begin
          if (failed_q && connect_i) begin
            if (int'(retry_q) <= MAX_RETRY) begin
              state_d = ST_BACKOFF;
            end else begin
              state_d    = ST_FAIL;
              fail_pulse = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BACKOFF: begin
        if (!connect_i) begin
          state_d = ST_IDLE;
        end else if (tmr_hit) begin
          state_d = ST_REQ_OPEN;
        end
      end
      ST_FAIL: begin
        if (!connect_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      mode_q   <= CMD_OPEN;
      retry_q  <= '0;
      failed_q <= 1'b0;
      cancel_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_pulse;
      if (latch_open) begin
        addr_q  <= address_i;
        mode_q  <= listen_i ? CMD_LISTEN : CMD_OPEN;
        retry_q <= '0;
      end else if (retry_inc && (retry_q != 4'hF)) begin
        retry_q <= retry_q + 4'd1;
      end
      // Held through REQ_CLOSE so the post-ack decision sees why the close began.
      if (state_q != ST_REQ_CLOSE) begin
        failed_q <= fail_att;
      end
      if (state_q == ST_REQ_OPEN) begin
        cancel_q <= cancel_q | ~connect_i;
      end else begin
        cancel_q <= 1'b0;
      end
    end
  end

  assign toe.toe_req_o  = (state_q == ST_REQ_OPEN) || (state_q == ST_REQ_CLOSE);
  assign toe.toe_cmd_o  = (state_q == ST_REQ_CLOSE) ? CMD_CLOSE : mode_q;
  assign toe.toe_addr_o = addr_q;
  assign link_up_o      = (state_q == ST_UP);
  assign link_fail_o    = fail_q;
  assign retry_cnt_o    = retry_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fix_tcp_link_ctrl.sv
// Bench for fix_tcp_link_ctrl: TOE responder with programmable ack delay, a
// command scoreboard (expected {cmd,addr} queue) and directed scenarios.
module tb_fix_tcp_link_ctrl;
  import fix_tcp_pkg::*;

  localparam int TO = 40;
  localparam int BO = 20;
  localparam int MR = 3;
  localparam int WD = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL global_timeout cyc=%0d limit=20000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  // ---------------- DUT ----------------
  logic       connect = 1'b0;
  addr_t      address = '0;
  logic       listen = 1'b0;
  logic       rx_act = 1'b0;
  logic       link_up, link_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  fix_tcp_link_ctrl_if tif();

  fix_tcp_link_ctrl #(
    .TIMEOUT_CYC(TO), .BACKOFF_CYC(BO), .MAX_RETRY(MR), .WDOG_CYC(WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .connect_i     (connect),
    .address_i     (address),
    .listen_i      (listen),
    .toe           (tif),
    .rx_activity_i (rx_act),
    .link_up_o     (link_up),
    .link_fail_o   (link_fail),
    .retry_cnt_o   (retry_cnt),
    .state_o       (state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- TOE responder ----------------
  int ack_dly = 2;
  int age;
  initial begin
    tif.toe_ack_i = 1'b0;
    age = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        tif.toe_ack_i = 1'b0; age = 0;
      end else if (tif.toe_ack_i) begin
        tif.toe_ack_i = 1'b0; age = 0;
      end else if (tif.toe_req_o) begin
        if (age >= ack_dly) tif.toe_ack_i = 1'b1;
        else age++;
      end else begin
        age = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [17:0] exp_q[$];
  int          hs_q[$];
  logic [17:0] bus, prev_bus, sb_e;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_up = 1'b0;
  int          fail_cnt = 0, stable_err = 0;
  int          rise_cyc = 0, hs_last = 0, down_cyc = 0;

  assign bus = {tif.toe_cmd_o, tif.toe_addr_o};

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_up = 1'b0;
    end else begin
      if (link_fail) fail_cnt++;
      if (tif.toe_req_o && !prev_req) rise_cyc = cyc;
      if (tif.toe_req_o && prev_req && !prev_ack && (bus != prev_bus)) stable_err++;
      if (prev_up && !link_up) down_cyc = cyc;
      // req & ack seen here means the transfer happens at the coming edge.
      if (tif.toe_req_o && tif.toe_ack_i) begin
        hs_last = cyc + 1;
        hs_q.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_cmd", 32'(bus), 32'hFFFF_FFFF);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_cmd_addr", 32'(bus), 32'(sb_e));
        end
      end
      prev_req = tif.toe_req_o; prev_ack = tif.toe_ack_i;
      prev_bus = bus;           prev_up  = link_up;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while ((state !== s) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic start_link(input addr_t a, input logic lst);
    address = a;
    listen  = lst;
    connect = 1'b1;
    exp_q.push_back({(lst ? CMD_LISTEN : CMD_OPEN), a});
  endtask

  // ---------------- stimulus ----------------
  int f0;
  int last_rx;

  initial begin
    tif.toe_est_i   = 1'b0;
    tif.toe_abort_i = 1'b0;

    // Reset values
    tick(3);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_req", 32'(tif.toe_req_o), 0);
    check("rst_cmd", 32'(tif.toe_cmd_o), 0);
    check("rst_addr", 32'(tif.toe_addr_o), 0);
    check("rst_outs", 32'({link_up, link_fail, retry_cnt}), 0);
    rst = 1'b0;
    tick(2);

    // Active open, established, orderly teardown
    ack_dly = 2;
    start_link(16'h1234, 1'b0);
    tick(1);
    address = 16'hFFFF;  // must not disturb the latched address
    wait_state(ST_WAIT_EST, 20, "t1_wait_est");
    check("t1_addr_latched", 32'(tif.toe_addr_o), 32'h1234);
    tick(10);
    tif.toe_est_i = 1'b1;
    wait_state(ST_UP, 5, "t1_up");
    check("t1_link_up", 32'(link_up), 1);
    f0 = fail_cnt;
    connect = 1'b0;
    exp_q.push_back({CMD_CLOSE, 16'h1234});
    wait_state(ST_IDLE, 20, "t1_idle");
    tif.toe_est_i = 1'b0;
    tick(2);
    check("t1_no_fail", 32'(fail_cnt - f0), 0);

    // Listen mode never times out
    f0 = fail_cnt;
    start_link(16'hABCD, 1'b1);
    wait_state(ST_WAIT_EST, 20, "t2_wait_est");
    tick(3 * TO);
    check("t2_still_wait", 32'(state), 32'(ST_WAIT_EST));
    check("t2_no_retry", 32'(retry_cnt), 0);
    check("t2_no_fail", 32'(fail_cnt - f0), 0);
    connect = 1'b0;
    exp_q.push_back({CMD_CLOSE, 16'hABCD});
    wait_state(ST_IDLE, 20, "t2_idle");

    // Active open with no establishment: 1 + MR attempts, then FAIL
    tick(2);
    hs_q.delete();
    f0 = fail_cnt;
    for (int i = 0; i <= MR; i++) begin
      exp_q.push_back({CMD_OPEN, 16'h5A5A});
      exp_q.push_back({CMD_CLOSE, 16'h5A5A});
    end
    address = 16'h5A5A; listen = 1'b0; connect = 1'b1;
    wait_state(ST_FAIL, 800, "t3_fail_state");
    tick(5);
    check("t3_fail_hold", 32'(state), 32'(ST_FAIL));
    check("t3_retry_cnt", 32'(retry_cnt), 32'(MR + 1));
    check("t3_fail_once", 32'(fail_cnt - f0), 1);
    check("t3_hs_count", 32'(hs_q.size()), 32'(2 * (MR + 1)));
    for (int i = 0; i + 1 < hs_q.size(); i++) begin
      // open->close: full timeout plus close handshake; close->open: back-off plus open handshake
      check((i % 2 == 0) ? "t3_timeout_gap" : "t3_backoff_gap",
            32'(hs_q[i+1] - hs_q[i]),
            32'(((i % 2 == 0) ? TO : BO) + ack_dly + 1));
    end
    connect = 1'b0;
    wait_state(ST_IDLE, 5, "t3_idle");

    // UP, then abort together with connect drop: abort wins
    tick(2);
    start_link(16'h0F0F, 1'b0);
    wait_state(ST_WAIT_EST, 20, "t4_wait_est");
    check("t4_retry_cleared", 32'(retry_cnt), 0);
    tif.toe_est_i = 1'b1;
    wait_state(ST_UP, 5, "t4_up");
    f0 = fail_cnt;
    exp_q.push_back({CMD_CLOSE, 16'h0F0F});
    tif.toe_abort_i = 1'b1;
    connect = 1'b0;
    tick(1);
    tif.toe_abort_i = 1'b0;
    tif.toe_est_i = 1'b0;
    check("t4_close_state", 32'(state), 32'(ST_REQ_CLOSE));
    check("t4_link_down", 32'(link_up), 0);
    check("t4_fail_pulse", 32'(link_fail), 1);
    wait_state(ST_IDLE, 20, "t4_idle");
    tick(3);
    check("t4_fail_once", 32'(fail_cnt - f0), 1);

    // Ack withheld for 20 cycles
    ack_dly = 20;
    stable_err = 0;
    start_link(16'h7777, 1'b0);
    wait_state(ST_WAIT_EST, 60, "t5_wait_est");
    check("t5_req_low", 32'(tif.toe_req_o), 0);
    check("t5_ack_latency", 32'(hs_last - rise_cyc), 32'(ack_dly + 1));
    check("t5_stable", 32'(stable_err), 0);
    connect = 1'b0;
    exp_q.push_back({CMD_CLOSE, 16'h7777});
    wait_state(ST_IDLE, 60, "t5_idle");
    check("t5_stable_close", 32'(stable_err), 0);
    ack_dly = 2;

    // Receive watchdog
    tick(2);
    start_link(16'h4242, 1'b0);
    wait_state(ST_WAIT_EST, 20, "t6_wait_est");
    tif.toe_est_i = 1'b1;
    wait_state(ST_UP, 5, "t6_up");
    f0 = fail_cnt;
`ifdef FIX_LINK_WDOG_EN
    for (int i = 0; i < 4; i++) begin
      tick(49);
      rx_act = 1'b1;
      last_rx = cyc + 1;  // edge that samples the pulse
      tick(1);
      rx_act = 1'b0;
    end
    check("t6_up_with_rx", 32'(state), 32'(ST_UP));
    exp_q.push_back({CMD_CLOSE, 16'h4242});
    wait_state(ST_REQ_CLOSE, WD + 10, "t6_wdog_close");
    tick(1);
    check("t6_drop_delay", 32'(down_cyc - last_rx), 32'(WD));
    check("t6_fail_once", 32'(fail_cnt - f0), 1);
    wait_state(ST_IDLE, 20, "t6_idle");
    tif.toe_est_i = 1'b0;
    connect = 1'b0;
    tick(2);
`else
    last_rx = 0;
    tick(3 * WD);
    check("t6_no_wdog", 32'(state), 32'(ST_UP));
    check("t6_no_fail", 32'(fail_cnt - f0), 0);
    connect = 1'b0;
    exp_q.push_back({CMD_CLOSE, 16'h4242});
    wait_state(ST_IDLE, 20, "t6_idle");
    tif.toe_est_i = 1'b0;
`endif

    tick(5);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
